// File: rtl/mips_wb_regfile_pkg.sv
// Shared MIPS definitions: opcodes, instruction field positions and the
// writeback/regfile state type. Imported by the regfile and the hazard unit.
package mips_pkg;

    localparam int DATA_W   = 32;
    localparam int INST_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;
    localparam int RD_MSB = 15;
    localparam int RD_LSB = 11;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        IDLE,
        CLEAR
    } wb_state_t;

endpackage

// File: rtl/mips_wb_regfile_if.sv
// Writeback / register-file bus: writeback handshake, two read ports,
// clear control and the committed-write report.
interface mips_wb_regfile_if;
    import mips_pkg::*;

    logic              wb_valid;
    logic              wb_ready;
    logic [INST_W-1:0] wb_inst;
    logic [DATA_W-1:0] wb_result;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              clr_req;
    logic              clr_busy;
    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_addr_o;

    modport master (
        output wb_valid, wb_inst, wb_result, rs_addr, rt_addr, clr_req,
        input  wb_ready, rs_data, rt_data, clr_busy, wr_en_o, wr_addr_o
    );

    modport slave (
        input  wb_valid, wb_inst, wb_result, rs_addr, rt_addr, clr_req,
        output wb_ready, rs_data, rt_data, clr_busy, wr_en_o, wr_addr_o
    );

endinterface

// File: rtl/mips_wb_regfile_dest_decode.sv
// Maps an instruction to its destination register: rd for R-type, none for
// j/beq/bne/sw, rt otherwise. Shared with the hazard unit.
module mips_wb_dest_decode
    import mips_pkg::*;
(
    input  logic [INST_W-1:0] inst,
    output logic              has_dest,
    output logic [ADDR_W-1:0] dest
);

    logic [5:0] op;
    logic       unused_bits;

    assign op          = inst[OP_MSB:OP_LSB];
    assign unused_bits = ^{inst[RS_MSB:RS_LSB], inst[RD_LSB-1:0]};

    always_comb begin
        has_dest = 1'b1;
        dest     = inst[RT_MSB:RT_LSB];
        case (op)
            OP_RTYPE: dest = inst[RD_MSB:RD_LSB];
            OP_J, OP_BEQ, OP_BNE, OP_SW: begin
                has_dest = 1'b0;
                dest     = REG_ZERO;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_wb_regfile.sv
// Writeback stage plus 32x32 register file with a sequenced clear engine.
// Define WB_BYPASS_EN to forward a committing result onto the read ports.
module mips_wb_regfile
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    mips_wb_regfile_if.slave   bus
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    wb_state_t         state_q;
    wb_state_t         state_d;
    logic [ADDR_W-1:0] clr_cnt;
    logic              has_dest;
    logic [ADDR_W-1:0] dest;
    logic              commit;

    mips_wb_dest_decode u_dest_decode (
        .inst     (bus.wb_inst),
        .has_dest (has_dest),
        .dest     (dest)
    );

    assign bus.wb_ready = (state_q == IDLE);
    assign bus.clr_busy = (state_q == CLEAR);
    assign commit       = bus.wb_valid & bus.wb_ready & has_dest & (dest != REG_ZERO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.clr_req) state_d = CLEAR;
            CLEAR:   if (clr_cnt == ADDR_W'(NUM_REGS - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counter is zero on entry to CLEAR and wraps 31 -> 0 on the last step
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     clr_cnt <= '0;
        else if (state_q == CLEAR)   clr_cnt <= clr_cnt + 5'd1;
        else                         clr_cnt <= '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (state_q == CLEAR) begin
            regs[clr_cnt] <= '0;
        end else if (commit) begin
            regs[dest] <= bus.wb_result;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.wr_en_o   <= 1'b0;
            bus.wr_addr_o <= REG_ZERO;
        end else begin
            bus.wr_en_o <= commit;
            if (commit) bus.wr_addr_o <= dest;
        end
    end

    // commit already excludes CLEAR and $0, so forwarding needs no extra guard
    always_comb begin
        bus.rs_data = (bus.rs_addr == REG_ZERO) ? '0 : regs[bus.rs_addr];
        bus.rt_data = (bus.rt_addr == REG_ZERO) ? '0 : regs[bus.rt_addr];
`ifdef WB_BYPASS_EN
        if (commit && (bus.rs_addr == dest)) bus.rs_data = bus.wb_result;
        if (commit && (bus.rt_addr == dest)) bus.rt_data = bus.wb_result;
`else
`endif
    end

endmodule

// File: tb/tb_mips_wb_regfile.sv
// Scoreboard bench for mips_wb_regfile: writes, decode cases, clear sequence,
// reset during clear and same-cycle read behaviour with or without WB_BYPASS_EN.
module tb_mips_wb_regfile;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    exp_t        sbq[$];
    logic [31:0] model [32];
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    mips_wb_regfile_if bus ();

    mips_wb_regfile dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic expectPush(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sbq.push_back(e);
    endtask

    task automatic popCompare(input logic [31:0] obs);
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL sb_underflow: got 0x%08h expected nothing", obs);
        end else begin
            e = sbq.pop_front();
            checkOutput(e.tag, obs, e.val);
        end
    endtask

    task automatic readCheck(input string tag, input logic [4:0] a);
        bus.rs_addr = a;
        bus.rt_addr = a;
        #1;
        expectPush($sformatf("%s_rs%0d", tag, a), model[a]);
        expectPush($sformatf("%s_rt%0d", tag, a), model[a]);
        popCompare(bus.rs_data);
        popCompare(bus.rt_data);
    endtask

    // One writeback beat: drive at negedge, compare the committed-write report after the edge
    task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [31:0] res,
                                 input logic clr, input logic exp_en, input logic [4:0] exp_addr);
        @(negedge clk);
        bus.wb_valid  = v;
        bus.wb_inst   = inst;
        bus.wb_result = res;
        bus.clr_req   = clr;
        expectPush("wr_en", {31'd0, exp_en});
        expectPush("wr_addr", {27'd0, exp_addr});
        @(posedge clk);
        #1;
        bus.wb_valid = 1'b0;
        bus.clr_req  = 1'b0;
        popCompare({31'd0, bus.wr_en_o});
        popCompare({27'd0, bus.wr_addr_o});
    endtask

    initial begin
        int busy;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        bus.wb_valid  = 1'b0;
        bus.wb_inst   = 32'd0;
        bus.wb_result = 32'd0;
        bus.rs_addr   = 5'd0;
        bus.rt_addr   = 5'd0;
        bus.clr_req   = 1'b0;

        #1 rst = 1'b1;
        #9 rst = 1'b0;
        #1;
        checkOutput("rst_wb_ready", {31'd0, bus.wb_ready}, 32'd1);
        checkOutput("rst_clr_busy", {31'd0, bus.clr_busy}, 32'd0);
        checkOutput("rst_wr_en", {31'd0, bus.wr_en_o}, 32'd0);
        checkOutput("rst_wr_addr", {27'd0, bus.wr_addr_o}, 32'd0);
        for (int a = 0; a < 32; a++) readCheck("rst", 5'(a));

        // add $9,$10,$11
        applyStimulus(1'b1, 32'h014B4820, 32'h0000002A, 1'b0, 1'b1, 5'd9);
        model[9] = 32'h2A;
        readCheck("rtype", 5'd9);

        // andi $0 is dropped; wr_addr_o holds the previous address
        applyStimulus(1'b1, 32'h300070A4, 32'h0000FFFF, 1'b0, 1'b0, 5'd9);
        readCheck("wr_zero", 5'd0);

        applyStimulus(1'b1, 32'h3128000F, 32'h0000000A, 1'b0, 1'b1, 5'd8);
        model[8] = 32'h0A;
        readCheck("itype", 5'd8);

        // sw and beq: rt=8 would be the target if decode were wrong
        applyStimulus(1'b1, 32'hAD280004, 32'h00000055, 1'b0, 1'b0, 5'd8);
        applyStimulus(1'b1, 32'h11280003, 32'h00000055, 1'b0, 1'b0, 5'd8);
        readCheck("nodest", 5'd8);
        readCheck("nodest", 5'd9);

        // valid low: nothing commits
        applyStimulus(1'b0, 32'h20060000, 32'h00000066, 1'b0, 1'b0, 5'd8);
        readCheck("novalid", 5'd6);

        // Preload, then write $20 in the same cycle that clear is requested
        applyStimulus(1'b1, 32'h20050000, 32'h00001234, 1'b0, 1'b1, 5'd5);
        model[5] = 32'h1234;
        applyStimulus(1'b1, 32'h201F0000, 32'h0000ABCD, 1'b0, 1'b1, 5'd31);
        model[31] = 32'hABCD;
        applyStimulus(1'b1, 32'h20140000, 32'h00002020, 1'b1, 1'b1, 5'd20);
        model[20] = 32'h2020;
        busy = bus.clr_busy ? 1 : 0;
        for (int cyc = 1; cyc < 100 && bus.clr_busy; cyc++) begin
            @(negedge clk);
            bus.rs_addr = (cyc == 1) ? 5'd20 : 5'd31;
            if (cyc == 5) begin
                bus.wb_valid  = 1'b1;
                bus.wb_inst   = 32'h30070000;
                bus.wb_result = 32'h00000077;
            end
            if (cyc == 15) bus.clr_req = 1'b1;
            @(posedge clk);
            #1;
            bus.wb_valid = 1'b0;
            bus.clr_req  = 1'b0;
            if (bus.clr_busy) busy++;
            if (cyc == 1) checkOutput("clr_keep_r20", bus.rs_data, model[20]);
            if (cyc == 5) begin
                checkOutput("clr_keep_r31", bus.rs_data, model[31]);
                checkOutput("clr_wb_ready", {31'd0, bus.wb_ready}, 32'd0);
                checkOutput("clr_ignore_wr", {31'd0, bus.wr_en_o}, 32'd0);
            end
        end
        checkOutput("clr_cycles", busy, 32'd32);
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        checkOutput("post_clr_ready", {31'd0, bus.wb_ready}, 32'd1);
        readCheck("post_clr", 5'd5);
        readCheck("post_clr", 5'd7);
        readCheck("post_clr", 5'd20);
        readCheck("post_clr", 5'd31);

        // Reset during clear, before index 12 is reached
        applyStimulus(1'b1, 32'h200C0000, 32'h00000099, 1'b0, 1'b1, 5'd12);
        model[12] = 32'h99;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd12);
        for (int cyc = 1; cyc <= 10; cyc++) @(posedge clk);
        @(negedge clk);
        readCheck("mid_clr", 5'd12);
        rst = 1'b1;
        #1;
        model[12] = 32'd0;
        checkOutput("rstclr_busy", {31'd0, bus.clr_busy}, 32'd0);
        checkOutput("rstclr_ready", {31'd0, bus.wb_ready}, 32'd1);
        readCheck("rstclr", 5'd12);
        @(negedge clk);
        rst = 1'b0;

        // Same-cycle read of a committing write
        @(negedge clk);
        bus.rs_addr   = 5'd3;
        bus.rt_addr   = 5'd0;
        bus.wb_valid  = 1'b1;
        bus.wb_inst   = 32'h20030000;
        bus.wb_result = 32'hDEADBEEF;
        #1;
`ifdef WB_BYPASS_EN
        expectPush("byp_same", 32'hDEADBEEF);
`else
        expectPush("byp_same", 32'h0);
`endif
        expectPush("byp_zero", 32'h0);
        popCompare(bus.rs_data);
        popCompare(bus.rt_data);
        @(posedge clk);
        #1;
        bus.wb_valid = 1'b0;
        checkOutput("byp_next", bus.rs_data, 32'hDEADBEEF);
        checkOutput("byp_wr_en", {31'd0, bus.wr_en_o}, 32'd1);

        checkOutput("sb_drained", sbq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
